// File: rtl/addr_sequencer_pkg.sv
// Shared definitions for the instruction/operand address sequencer.
package addr_sequencer_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam logic [12:0] RAM_BASE = 13'h1800;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OPA_HI = 12;
  localparam int OPA_LO = 0;

  typedef enum logic [2:0] {
    FETCH_HI,
    FETCH_LO,
    ISSUE,
    OPND,
    HALTED
  } state_t;

endpackage

// File: rtl/addr_sequencer.sv
// Fetches 16-bit instructions byte-wise, hands them to the core and performs
// the single operand read or RAM-protected operand write each one requests.
module addr_sequencer
  import addr_sequencer_pkg::*;
#(
  parameter int ADDR_W = addr_sequencer_pkg::ADDR_W,
  parameter int DATA_W = addr_sequencer_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RAM_BASE = addr_sequencer_pkg::RAM_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] addr,
  output logic              rd,
  output logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic [15:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              cmd_rd,
  input  logic              cmd_wr,
  input  logic              cmd_jmp,
  input  logic              cmd_halt,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] opnd,
  output logic              opnd_vld,
  output logic              wr_err,
  output logic [ADDR_W-1:0] pc
);

  state_t            state, state_nxt;
  logic              op_wr;
  logic [ADDR_W-1:0] opnd_addr;
  logic              in_ram;

  assign opnd_addr = ir[OPA_HI:OPA_LO];
  assign in_ram    = (opnd_addr >= RAM_BASE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH_HI;
      pc       <= '0;
      ir       <= '0;
      opnd     <= '0;
      data_out <= '0;
      op_wr    <= 1'b0;
      opnd_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      opnd_vld <= 1'b0;
      case (state)
        FETCH_HI: begin
          ir[15:8] <= data_in;
          pc       <= pc + 1'b1;
        end
        FETCH_LO: begin
          ir[7:0] <= data_in;
          pc      <= pc + 1'b1;
        end
        ISSUE: begin
          if (ir_ready && !cmd_halt) begin
            if (cmd_jmp) begin
              pc <= opnd_addr;
            end else begin
              // op_wr selects the OPND flavour; cmd_wr dominates cmd_rd
              op_wr <= cmd_wr;
              if (cmd_wr) data_out <= st_data;
            end
          end
        end
        OPND: begin
          if (!op_wr) begin
            opnd     <= data_in;
            opnd_vld <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    addr      = pc;
    rd        = 1'b0;
    wr        = 1'b0;
    ir_valid  = 1'b0;
    wr_err    = 1'b0;
    case (state)
      FETCH_HI: begin
        rd        = 1'b1;
        state_nxt = FETCH_LO;
      end
      FETCH_LO: begin
        rd        = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        ir_valid = 1'b1;
        if (ir_ready) begin
          if (cmd_halt)                state_nxt = HALTED;
          else if (cmd_jmp)            state_nxt = FETCH_HI;
          else if (cmd_wr || cmd_rd)   state_nxt = OPND;
          else                         state_nxt = FETCH_HI;
        end
      end
      OPND: begin
        addr      = opnd_addr;
        state_nxt = FETCH_HI;
        if (op_wr) begin
          // rst masks the strobe in the cycle it is sampled so a reset
          // landing on the write cycle never commits the store
          if (in_ram) wr     = !rst;
          else        wr_err = 1'b1;
        end else begin
          rd = 1'b1;
        end
      end
      HALTED: ;
      default: state_nxt = FETCH_HI;
    endcase
  end

endmodule

// File: tb/tb_addr_sequencer.sv
// Bench for addr_sequencer: directed literal scenarios plus randomized
// commands checked every cycle against a scheduled-access reference model.
module tb_addr_sequencer;

  localparam logic [12:0] RAM_LO = 13'h1800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in;
  logic [12:0] addr;
  logic        rd, wr;
  logic [7:0]  data_out;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        cmd_rd = 1'b0, cmd_wr = 1'b0, cmd_jmp = 1'b0, cmd_halt = 1'b0;
  logic [7:0]  st_data = '0;
  logic [7:0]  opnd;
  logic        opnd_vld, wr_err;
  logic [12:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addr_sequencer #(.ADDR_W(13), .DATA_W(8), .RAM_BASE(13'h1800)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .addr(addr), .rd(rd), .wr(wr),
    .data_out(data_out), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .cmd_jmp(cmd_jmp), .cmd_halt(cmd_halt),
    .st_data(st_data), .opnd(opnd), .opnd_vld(opnd_vld), .wr_err(wr_err), .pc(pc)
  );

  // memory environment: combinational read, writes committed on the strobe
  logic [7:0] mem [0:8191];
  always_comb data_in = mem[addr];
  always @(posedge clk) if (wr === 1'b1) mem[addr] <= data_out;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of the bus accesses still owed for the current
  // instruction; an empty queue while not halted schedules the next fetch.
  typedef enum {K_FETCH_HI, K_FETCH_LO, K_ISSUE, K_RD, K_WR, K_ERR} kind_t;
  typedef struct { kind_t kind; logic [12:0] a; logic [7:0] d; } acc_t;
  acc_t        q[$];
  logic [12:0] m_pc;
  logic [15:0] m_ir;
  logic [7:0]  m_opnd;
  logic        m_vld;
  logic        m_halted;
  bit          chk_en = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_pc = '0; m_ir = '0; m_opnd = '0; m_vld = 1'b0; m_halted = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (q.size() > 0) begin
        acc_t s;
        s = q[0];
        case (s.kind)
          K_FETCH_HI: begin m_ir[15:8] = mem[m_pc]; m_pc = m_pc + 13'd1; void'(q.pop_front()); end
          K_FETCH_LO: begin m_ir[7:0]  = mem[m_pc]; m_pc = m_pc + 13'd1; void'(q.pop_front()); end
          K_ISSUE: if (ir_ready) begin
            void'(q.pop_front());
            if (cmd_halt)     m_halted = 1'b1;
            else if (cmd_jmp) m_pc = m_ir[12:0];
            else if (cmd_wr) begin
              if (m_ir[12:0] >= RAM_LO) q.push_back('{K_WR, m_ir[12:0], st_data});
              else                      q.push_back('{K_ERR, m_ir[12:0], 8'h00});
            end else if (cmd_rd)        q.push_back('{K_RD, m_ir[12:0], 8'h00});
          end
          K_RD: begin m_opnd = mem[s.a]; m_vld = 1'b1; void'(q.pop_front()); end
          default: void'(q.pop_front());
        endcase
      end
    end
    if (!m_halted && q.size() == 0) begin
      q.push_back('{K_FETCH_HI, 13'h0, 8'h0});
      q.push_back('{K_FETCH_LO, 13'h0, 8'h0});
      q.push_back('{K_ISSUE,    13'h0, 8'h0});
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("rd_wr_excl", {31'b0, rd & wr}, 32'd0);
    if (rst) begin
      check("wr_in_rst", wr, 0);
    end else begin
      check("pc", pc, m_pc);
      check("opnd_vld", opnd_vld, m_vld);
      if (m_vld) check("opnd", opnd, m_opnd);
      if (q.size() == 0) begin
        check("halt_rd", rd, 0); check("halt_wr", wr, 0);
        check("halt_irv", ir_valid, 0); check("halt_addr", addr, m_pc);
        check("halt_werr", wr_err, 0);
      end else begin
        case (q[0].kind)
          K_FETCH_HI, K_FETCH_LO: begin
            check("fetch_rd", rd, 1); check("fetch_wr", wr, 0);
            check("fetch_addr", addr, m_pc); check("fetch_irv", ir_valid, 0);
            check("fetch_werr", wr_err, 0);
          end
          K_ISSUE: begin
            check("issue_irv", ir_valid, 1); check("issue_rd", rd, 0);
            check("issue_wr", wr, 0); check("issue_addr", addr, m_pc);
            check("issue_ir", ir, m_ir); check("issue_werr", wr_err, 0);
          end
          K_RD: begin
            check("oprd_rd", rd, 1); check("oprd_wr", wr, 0);
            check("oprd_addr", addr, q[0].a); check("oprd_werr", wr_err, 0);
          end
          K_WR: begin
            check("opwr_wr", wr, 1); check("opwr_addr", addr, q[0].a);
            check("opwr_data", data_out, q[0].d); check("opwr_werr", wr_err, 0);
          end
          K_ERR: begin
            check("operr_wr", wr, 0); check("operr_werr", wr_err, 1);
            check("operr_irv", ir_valid, 0);
          end
          default: ;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (ir_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("issue_wait", ir_valid, 1);
  endtask

  task automatic handshake(input logic r, input logic w, input logic j,
                           input logic h, input logic [7:0] sd);
    ir_ready = 1'b1; cmd_rd = r; cmd_wr = w; cmd_jmp = j; cmd_halt = h; st_data = sd;
    step();
    ir_ready = 1'b0; cmd_rd = 1'b0; cmd_wr = 1'b0; cmd_jmp = 1'b0; cmd_halt = 1'b0;
  endtask

  initial begin
    int halt_cnt;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'hA0;  mem[1] = 8'h05;
    mem[2] = 8'h19;  mem[3] = 8'h00;
    mem[4] = 8'h01;  mem[5] = 8'h00;
    mem[6] = 8'h1F;  mem[7] = 8'hFF;
    mem[8] = 8'hE0;  mem[9] = 8'h10;
    mem[13'h10] = 8'h1F; mem[13'h11] = 8'hFE;
    mem[13'h1FFE] = 8'h00; mem[13'h1FFF] = 8'h3C;
    mem[13'h3C] = 8'h18; mem[13'h3D] = 8'h20;
    mem[13'h1820] = 8'h00;

    rst = 1'b1;
    step(); step();
    check("rst_pc", pc, 0);          check("rst_ir", ir, 0);
    check("rst_irv", ir_valid, 0);   check("rst_wr", wr, 0);
    check("rst_vld", opnd_vld, 0);   check("rst_opnd", opnd, 0);
    check("rst_dout", data_out, 0);  check("rst_werr", wr_err, 0);
    rst = 1'b0;
    check("post_rst_addr", addr, 0); check("post_rst_rd", rd, 1);

    step(); step();
    check("first_ir", ir, 16'hA005); check("first_pc", pc, 2);
    check("first_irv", ir_valid, 1);
    handshake(0, 0, 0, 0, 8'h00);
    check("irv_drop", ir_valid, 0);  check("next_addr", addr, 2);
    check("next_rd", rd, 1);

    wait_issue();
    check("st_ir", ir, 16'h1900);
    handshake(0, 1, 0, 0, 8'h5A);
    check("st_wr", wr, 1);           check("st_addr", addr, 13'h1900);
    check("st_data", data_out, 8'h5A); check("st_rd", rd, 0);
    step();
    check("st_after_wr", wr, 0);     check("st_after_rd", rd, 1);
    check("st_after_addr", addr, 4);

    wait_issue();
    check("rom_ir", ir, 16'h0100);
    handshake(0, 1, 0, 0, 8'h77);
    check("rom_wr", wr, 0);          check("rom_werr", wr_err, 1);
    step();
    check("rom_werr_end", wr_err, 0); check("rom_wr_end", wr, 0);
    check("rom_next_addr", addr, 6);

    wait_issue();
    check("ld_ir", ir, 16'h1FFF);
    handshake(1, 0, 0, 0, 8'h00);
    check("ld_rd", rd, 1);           check("ld_addr", addr, 13'h1FFF);
    step();
    check("ld_vld", opnd_vld, 1);    check("ld_opnd", opnd, 8'h3C);
    step();
    check("ld_vld_end", opnd_vld, 0);

    wait_issue();
    check("jmp_ir", ir, 16'hE010);
    handshake(1, 0, 1, 0, 8'h00);
    check("jmp_addr", addr, 13'h0010); check("jmp_rd", rd, 1);
    check("jmp_pc", pc, 13'h0010);

    wait_issue();
    handshake(0, 0, 1, 0, 8'h00);
    check("wrap_a0", addr, 13'h1FFE);
    step();
    check("wrap_a1", addr, 13'h1FFF);
    step();
    check("wrap_pc", pc, 13'h0000);  check("wrap_ir", ir, 16'h003C);
    handshake(0, 0, 1, 0, 8'h00);
    check("wrap_jmp", addr, 13'h003C);

    wait_issue();
    check("rstwr_ir", ir, 16'h1820);
    handshake(0, 1, 0, 0, 8'hC3);
    check("rstwr_wr", wr, 1);
    rst = 1'b1;
    #1;
    check("rstwr_masked", wr, 0);
    step();
    rst = 1'b0;
    check("rstwr_after_wr", wr, 0);  check("rstwr_addr", addr, 0);
    check("rstwr_rd", rd, 1);        check("rstwr_pc", pc, 0);
    check("rstwr_mem", mem[13'h1820], 8'h00);

    wait_issue();
    handshake(1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      ir_ready = 1'($urandom_range(0, 1)); cmd_rd = 1'($urandom_range(0, 1));
      cmd_wr = 1'($urandom_range(0, 1));   cmd_jmp = 1'($urandom_range(0, 1));
      step();
      check("halt_hold_rd", rd, 0);  check("halt_hold_wr", wr, 0);
      check("halt_hold_irv", ir_valid, 0); check("halt_hold_pc", pc, 2);
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    halt_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      ir_ready = 1'($urandom_range(0, 1));
      cmd_rd   = 1'($urandom_range(0, 1));
      cmd_wr   = 1'($urandom_range(0, 1));
      cmd_jmp  = ($urandom_range(0, 5) == 0);
      cmd_halt = ($urandom_range(0, 15) == 0);
      st_data  = 8'($urandom_range(0, 255));
      halt_cnt = m_halted ? halt_cnt + 1 : 0;
      rst      = ($urandom_range(0, 199) == 0) || (halt_cnt > 3);
      step();
    end
    rst = 1'b0; ir_ready = 1'b0;
    cmd_rd = 1'b0; cmd_wr = 1'b0; cmd_jmp = 1'b0; cmd_halt = 1'b0;
    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
